// File: rtl/tt_um_badhri_uart_pkg.sv
// Shared types and constants for the tt_um_badhri_uart transmitter and receiver.
// Build option: UART_PARITY_EN adds the even-parity states to both state enums.
package tt_um_badhri_uart_pkg;

    localparam int   DATA_W    = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/badhri_uart_rx.sv
// UART receiver: two-flop synchronizer, mid-bit sampling, frame/parity error flags.
// Build option: UART_PARITY_EN enables the even-parity check.
module badhri_uart_rx
    import tt_um_badhri_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_err_o,
    output logic              parity_err_o
);
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              meta_q, sync_q, prev_q;
`ifdef UART_PARITY_EN
    logic              perr_q, perr_d;
    logic              pbad_q, pbad_d;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_PARITY_EN
        perr_d  = perr_q;
        pbad_d  = pbad_q;
`endif
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (sync_q == START_BIT) ? RX_DATA : RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shreg_d = {sync_q, shreg_q[DATA_W-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    pbad_d  = sync_q ^ (^shreg_q);
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (sync_q == STOP_BIT) begin
                        ferr_d  = 1'b0;
                        state_d = RX_IDLE;
`ifdef UART_PARITY_EN
                        perr_d  = pbad_q;
                        if (!pbad_q) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shreg_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (sync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Synchronizer resets low so a line already low at reset release is not taken as a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q  <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
`ifdef UART_PARITY_EN
            perr_q  <= perr_d;
            pbad_q  <= pbad_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
`ifdef UART_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: rtl/tt_um_badhri_uart.sv
// Tiny Tapeout UART tile: transmitter FSM and pin mapping, receiver in badhri_uart_rx.
// Build option: UART_PARITY_EN inserts/checks an even-parity bit.
module tt_um_badhri_uart
    import tt_um_badhri_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    tx_state_e         tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_busy_q, tx_busy_d;

    logic              tx_start;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, rx_ferr, rx_perr;
    logic              unused_ok;

    assign tx_start  = uio_in[1];
    assign unused_ok = &{1'b0, ena, uio_in[7:2]};

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_line_d  = tx_line_q;
        tx_busy_d  = tx_busy_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = STOP_BIT;
                tx_busy_d = 1'b0;
                if (tx_start) begin
                    tx_data_d  = ui_in;
                    tx_line_d  = START_BIT;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_line_d  = tx_data_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        tx_line_d  = ^tx_data_q;
                        tx_state_d = TX_PARITY;
`else
                        tx_line_d  = STOP_BIT;
                        tx_state_d = TX_STOP;
`endif
                    end else begin
                        tx_idx_d  = tx_idx_q + 1'b1;
                        tx_line_d = tx_data_q[tx_idx_d];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_line_d  = STOP_BIT;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // rst_n is active-high despite its name: 1 holds the block in reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_line_q  <= STOP_BIT;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_line_q  <= tx_line_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    badhri_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst_n),
        .rx_i        (uio_in[0]),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr),
        .parity_err_o(rx_perr)
    );

    assign uo_out  = rx_data;
    assign uio_out = {1'b0, rx_perr, rx_ferr, rx_valid, tx_busy_q, tx_line_q, 2'b00};
    assign uio_oe  = 8'b0111_1100;

endmodule

// File: tb/tb_tt_um_badhri_uart.sv
// Scoreboard bench for tt_um_badhri_uart: stimulus pushes expected bytes, monitors pop and compare.
`timescale 1ns/1ps
module tb_tt_um_badhri_uart;
    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int BUSY_LEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic       tx_start, rx_line, loop_en, corrupt;
    logic       tx_line, tx_busy, rx_valid, frame_err, parity_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    assign uio_in     = {6'b0, tx_start, (loop_en ? uio_out[2] : rx_line) ^ corrupt};
    assign tx_line    = uio_out[2];
    assign tx_busy    = uio_out[3];
    assign rx_valid   = uio_out[4];
    assign frame_err  = uio_out[5];
    assign parity_err = uio_out[6];

    always #5 clk = ~clk;

    tt_um_badhri_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic stop_v, input logic par_flip);
        for (int b = 0; b < NBITS; b++) begin
            if (b == NBITS - 1) rx_line = stop_v;
            else                rx_line = frame_bit(d, b) ^ ((b == 9) && par_flip);
            repeat (CPB) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic wait_busy(input logic v, input string name);
        int n = 0;
        while (tx_busy !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, tx_busy, v);
    endtask

    // TX monitor: every cycle of each bit must hold the expected level.
    initial begin : tx_monitor
        logic [7:0] exp_b;
        logic       got, want;
        forever begin
            @(negedge clk);
            if (!rst_n && tx_line == 1'b0 && tx_exp.size() > 0) begin
                exp_b = tx_exp.pop_front();
                for (int b = 0; b < NBITS; b++) begin
                    want = frame_bit(exp_b, b);
                    got  = want;
                    for (int c = 0; c < CPB; c++) begin
                        if (tx_line !== want) got = tx_line;
                        @(negedge clk);
                    end
                    check($sformatf("tx_bit%0d_of_%02h", b, exp_b), got, want);
                end
            end
        end
    end

    // RX monitor: each rx_valid pulse must match the next queued byte and last one cycle.
    initial begin : rx_monitor
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (!rst_n && rx_valid === 1'b1) begin
                if (rx_exp.size() == 0) begin
                    check("rx_unexpected_valid", rx_valid, 1'b0);
                end else begin
                    exp_b = rx_exp.pop_front();
                    check("rx_byte", uo_out, exp_b);
                    check("rx_frame_err_on_valid", frame_err, 1'b0);
                    check("rx_parity_err_on_valid", parity_err, 1'b0);
                end
                @(negedge clk);
                check("rx_valid_one_cycle", rx_valid, 1'b0);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int busy_n;
        rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; tx_start = 1'b0;
        rx_line = 1'b1; loop_en = 1'b0; corrupt = 1'b0;

        // Reset state, held and after release
        repeat (3) @(negedge clk);
        check("rst_tx_line", tx_line, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_flags", uio_out[6:4], 3'b000);
        check("uio_oe", uio_oe, 8'h7C);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_tx_line", tx_line, 1'b1);
        check("idle_unused_bits", uio_out & 8'h83, 8'h00);
        check("idle_uo_out", uo_out, 8'h00);

        // TX 0xA5 with a stray tx_start mid-frame that must be ignored
        tx_exp.push_back(8'hA5);
        ui_in = 8'hA5; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0; ui_in = 8'hFF;
        check("tx_busy_rise", tx_busy, 1'b1);
        check("tx_start_low", tx_line, 1'b0);
        busy_n = 0;
        while (tx_busy && busy_n < 400) begin
            tx_start = (busy_n == 40);
            busy_n++;
            @(negedge clk);
        end
        tx_start = 1'b0;
        check("tx_busy_len", busy_n, BUSY_LEN);
        repeat (4) @(negedge clk);
        check("tx_no_restart", tx_busy, 1'b0);
        check("tx_idle_high", tx_line, 1'b1);
        check("tx_frames_seen", tx_exp.size(), 0);

        // RX good frame
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1, 1'b0);
        check("rx_uo_out_3c", uo_out, 8'h3C);
        check("rx_frame_err_clear", frame_err, 1'b0);

        // RX glitch
        rx_line = 1'b0;
        repeat (5) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_uo_out", uo_out, 8'h3C);
        check("glitch_frame_err", frame_err, 1'b0);
        check("glitch_parity_err", parity_err, 1'b0);

        // RX framing error then recovery
        send_rx(8'h99, 1'b0, 1'b0);
        check("ferr_set", frame_err, 1'b1);
        check("ferr_uo_out_kept", uo_out, 8'h3C);
        rx_exp.push_back(8'h55);
        send_rx(8'h55, 1'b1, 1'b0);
        check("ferr_cleared", frame_err, 1'b0);
        check("rx_uo_out_55", uo_out, 8'h55);

        // Loopback: three back-to-back frames with tx_start held high
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        tx_exp.push_back(8'h00); tx_exp.push_back(8'hFF); tx_exp.push_back(8'h81);
        rx_exp.push_back(8'h00); rx_exp.push_back(8'hFF); rx_exp.push_back(8'h81);
        ui_in = 8'h00; tx_start = 1'b1;
        wait_busy(1'b1, "lb_start0");
        ui_in = 8'hFF;
        wait_busy(1'b0, "lb_end0");
        @(negedge clk);
        check("lb_back_to_back1", tx_busy, 1'b1);
        ui_in = 8'h81;
        wait_busy(1'b0, "lb_end1");
        @(negedge clk);
        check("lb_back_to_back2", tx_busy, 1'b1);
        tx_start = 1'b0;
        wait_busy(1'b0, "lb_end2");
        repeat (4) @(negedge clk);
        check("lb_idle", tx_busy, 1'b0);
        check("lb_uo_out", uo_out, 8'h81);
        check("lb_rx_drained", rx_exp.size(), 0);

`ifdef UART_PARITY_EN
        // Loopback with the parity bit flipped on the wire
        tx_exp.push_back(8'h5A);
        ui_in = 8'h5A; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (9 * CPB) @(negedge clk);
        corrupt = 1'b1;
        repeat (CPB) @(negedge clk);
        corrupt = 1'b0;
        wait_busy(1'b0, "par_end");
        repeat (4) @(negedge clk);
        check("parity_err_set", parity_err, 1'b1);
        check("parity_uo_out_kept", uo_out, 8'h81);
        check("parity_frame_err", frame_err, 1'b0);
        tx_exp.push_back(8'h3C);
        rx_exp.push_back(8'h3C);
        ui_in = 8'h3C; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_busy(1'b0, "par_good_end");
        repeat (4) @(negedge clk);
        check("parity_err_cleared", parity_err, 1'b0);
        check("parity_uo_out_3c", uo_out, 8'h3C);
`endif

        // Reset in the middle of a looped-back frame
        ui_in = 8'hF0; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_line", tx_line, 1'b1);
        check("rst_mid_tx_busy", tx_busy, 1'b0);
        check("rst_mid_uo_out", uo_out, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("rst_mid_no_resume", tx_busy, 1'b0);
        check("rst_mid_line_high", tx_line, 1'b1);
        check("rst_mid_frame_err", frame_err, 1'b0);
        check("rst_mid_uo_out_after", uo_out, 8'h00);

        check("tx_queue_drained", tx_exp.size(), 0);
        check("rx_queue_drained", rx_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
